// File: rtl/picorv_awb_arb.sv
// ---------------------------------------------------------------------------
// picorv_awb_arb
//   Round-robin arbiter that merges NREQ asynchronous writeback requesters
//   into a single one-entry output stage feeding the core's register file.
//
//   Optional feature macro: PICORV_AWB_ARB_X0DROP_EN
//     When defined, granted requests targeting x0 are accepted but discarded.
//     They are never loaded into the output stage.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  [NREQ]       per-requester writeback request
//   req_ready  [NREQ]       per-requester accept (one-hot or zero)
//   req_addr   [5*NREQ]     destination register, requester i at [5i+4:5i]
//   req_data   [XLEN*NREQ]  writeback data, requester i at [XLEN*i +: XLEN]
//   awb_valid  writeback toward core valid (output stage FULL)
//   awb_ready  core accepts writeback
//   awb_addr   [5]          register address toward core
//   awb_data   [XLEN]       register data toward core
//   pending    [32]         one-hot of the register held in the output stage
// ---------------------------------------------------------------------------
module picorv_awb_arb #(
    parameter int XLEN = 32,
    parameter int NREQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [5*NREQ-1:0]      req_addr,
    input  logic [XLEN*NREQ-1:0]   req_data,
    output logic                   awb_valid,
    input  logic                   awb_ready,
    output logic [4:0]             awb_addr,
    output logic [XLEN-1:0]        awb_data,
    output logic [31:0]            pending
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t          r_state;
    logic [4:0]      r_addr;
    logic [XLEN-1:0] r_data;
    logic [IW-1:0]   r_last;

    logic            w_free;
    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_j;
    logic            w_grant;
    logic            w_load;
    logic [4:0]      w_gaddr;
    logic [XLEN-1:0] w_gdata;

    // The stage can take a new entry when empty or when its entry leaves now.
    assign w_free = (r_state == S_EMPTY) || awb_ready;

    // Search starts one past the last granted requester and wraps around.
    // The last granted requester is therefore checked last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_j     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = IW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_j]) begin
                w_found = 1'b1;
                w_sel   = w_j;
            end
        end
    end

    // Gating with reset keeps req_ready low in any cycle where reset is
    // sampled low. This also covers power-up before the first reset edge.
    assign w_grant   = reset && w_free && w_found;
    assign req_ready = w_grant ? (NREQ'(1) << w_sel) : '0;

    always_comb begin
        w_gaddr = '0;
        w_gdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IW'(i)) begin
                w_gaddr = req_addr[5*i +: 5];
                w_gdata = req_data[XLEN*i +: XLEN];
            end
        end
    end

`ifdef PICORV_AWB_ARB_X0DROP_EN
    // x0 writes are handshaken away. They still advance the pointer.
    assign w_load = w_grant && (w_gaddr != 5'd0);
`else
    assign w_load = w_grant;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= IW'(NREQ - 1);
        end else begin
            if (w_grant)
                r_last <= w_sel;
            // A load replaces any entry leaving this cycle.
            // A free stage with nothing to load (or a dropped x0) empties.
            if (w_load) begin
                r_state <= S_FULL;
                r_addr  <= w_gaddr;
                r_data  <= w_gdata;
            end else if (w_free) begin
                r_state <= S_EMPTY;
            end
        end
    end

    assign awb_valid = (r_state == S_FULL);
    assign awb_addr  = r_addr;
    assign awb_data  = r_data;
    assign pending   = (reset && r_state == S_FULL) ? (32'd1 << r_addr) : 32'd0;

endmodule
